// File: rtl/accel_desc_seq_if.sv
// Address-stream handshake between the descriptor sequencer (master) and its consumer (slave).
interface accel_desc_seq_if #(
  parameter int ADDR_W = 32
);
  logic              addr_valid;
  logic              addr_ready;
  logic [ADDR_W-1:0] addr_out;

  modport master (output addr_valid, output addr_out, input addr_ready);
  modport slave  (input addr_valid, input addr_out, output addr_ready);
endinterface

// File: rtl/accel_desc_seq.sv
// Descriptor channel bank plus one-channel word-address sequencer that holds the pipeline while busy.
// First address one cycle after start; address stalls while addr_ready is low; loads accepted in every state.
module accel_desc_seq #(
  parameter int ADDR_W     = 32,
  parameter int CNT_W      = 16,
  parameter int NUM_CH     = 2,
  parameter int WORD_BYTES = 4,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_startaddr_w,
  input  logic                     load_datasize_w,
  input  logic [CH_W-1:0]          load_ch_w,
  input  logic [ADDR_W-1:0]        load_data_w,
  input  logic                     start,
  input  logic [CH_W-1:0]          start_ch,
  accel_desc_seq_if.master         addr_if,
  output logic                     busy,
  output logic                     hold_o,
  output logic                     done,
  output logic [NUM_CH*ADDR_W-1:0] startaddr_flat,
  output logic [NUM_CH*CNT_W-1:0]  datasize_flat
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [CH_W:0] NCH = (CH_W+1)'(NUM_CH);

  logic [ADDR_W-1:0] r_startaddr [NUM_CH];
  logic [CNT_W-1:0]  r_datasize  [NUM_CH];

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_cur_addr, w_cur_nxt;
  logic [CNT_W-1:0]  r_remaining, w_rem_nxt;

  logic              w_load_ok;
  logic              w_start_ok;
  logic              w_hs;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [CNT_W-1:0]  w_sel_size;

  assign w_load_ok  = ({1'b0, load_ch_w} < NCH);
  assign w_start_ok = start && ({1'b0, start_ch} < NCH);

  // Start address wins when both strobes arrive together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_startaddr[i] <= '0;
        r_datasize[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_load_ok && (load_ch_w == CH_W'(i))) begin
          if (load_startaddr_w)
            r_startaddr[i] <= load_data_w;
          else if (load_datasize_w)
            r_datasize[i]  <= load_data_w[CNT_W-1:0];
        end
      end
    end
  end

  always_comb begin
    startaddr_flat = '0;
    datasize_flat  = '0;
    w_sel_addr     = '0;
    w_sel_size     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      startaddr_flat[i*ADDR_W +: ADDR_W] = r_startaddr[i];
      datasize_flat[i*CNT_W +: CNT_W]    = r_datasize[i];
      if (start_ch == CH_W'(i)) begin
        w_sel_addr = r_startaddr[i];
        w_sel_size = r_datasize[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cur_addr  <= '0;
      r_remaining <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cur_addr  <= w_cur_nxt;
      r_remaining <= w_rem_nxt;
    end
  end

  // The running sequence owns private copies, so later loads cannot disturb it.
  always_comb begin
    w_state_nxt = r_state;
    w_cur_nxt   = r_cur_addr;
    w_rem_nxt   = r_remaining;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) begin
          w_cur_nxt   = w_sel_addr;
          w_rem_nxt   = w_sel_size;
          w_state_nxt = (w_sel_size != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (w_hs) begin
          w_cur_nxt = r_cur_addr + ADDR_W'(WORD_BYTES);
          w_rem_nxt = r_remaining - CNT_W'(1);
          if (r_remaining == CNT_W'(1))
            w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign addr_if.addr_valid = (r_state == S_RUN);
  assign addr_if.addr_out   = (r_state == S_RUN) ? r_cur_addr : '0;
  assign w_hs               = addr_if.addr_valid & addr_if.addr_ready;
  assign busy               = (r_state != S_IDLE);
  assign hold_o             = busy;
  assign done               = (r_state == S_DONE);

endmodule
